// File: rtl/btb_update_ctrl.sv
// ----------------------------------------------------------------------------
// btb_update_ctrl
//
// Write-side controller for the set-associative branch target buffer.
// Resolved-branch records from execute are queued in a small FIFO and
// processed one at a time:
//   IDLE   -> pop a record into the holding registers
//   LOOKUP -> present the record to the ways and sample way_empty to decide
//             between updating the hit line and allocating a new one
//   WRITE  -> fire exactly one allocate or update strobe, then pop the next
//             record straight into LOOKUP if one is waiting
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous, active-low reset
//   res_valid    resolution record valid
//   res_ready    record accepted when res_valid & res_ready (registered count only)
//   res_pc       resolved branch PC
//   res_target   resolved branch target
//   res_taken    branch was taken
//   res_hit      fetch-time BTB lookup hit
//   res_hit_way  way that hit (ignored on a miss)
//   way_empty    per-way empty flags for the set addressed by entry_pc
//   entry_pc     PC presented to all ways
//   entry_target target presented to all ways
//   entry_en     one-hot allocate strobe
//   update_en    one-hot predictor-update strobe
//   jump_en      taken outcome accompanying a strobe
//   busy         FIFO non-empty or FSM not in IDLE
//   evict_count  saturating count of allocations that replaced a valid line
// ----------------------------------------------------------------------------
module btb_update_ctrl #(
    parameter int NUM_WAYS   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        res_valid,
    output logic                        res_ready,
    input  logic [15:0]                 res_pc,
    input  logic [15:0]                 res_target,
    input  logic                        res_taken,
    input  logic                        res_hit,
    input  logic [$clog2(NUM_WAYS)-1:0] res_hit_way,
    input  logic [NUM_WAYS-1:0]         way_empty,
    output logic [15:0]                 entry_pc,
    output logic [15:0]                 entry_target,
    output logic [NUM_WAYS-1:0]         entry_en,
    output logic [NUM_WAYS-1:0]         update_en,
    output logic                        jump_en,
    output logic                        busy,
    output logic [7:0]                  evict_count
);

    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = 16 + 16 + 1 + 1 + WAY_W;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;

    // ------------------------------------------------------------------
    // Resolution FIFO
    // ------------------------------------------------------------------
    logic [REC_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push;
    logic             pop;
    logic             fifo_nempty;
    logic [REC_W-1:0] rec_in;
    logic [REC_W-1:0] head;
    logic [15:0]      head_pc;
    logic [15:0]      head_tgt;
    logic             head_taken;
    logic             head_hit;
    logic [WAY_W-1:0] head_hw;

    // ------------------------------------------------------------------
    // FSM, holding registers and registered outputs
    // ------------------------------------------------------------------
    logic [1:0]          state_q, state_d;
    logic [15:0]         entry_pc_q, entry_pc_d;
    logic [15:0]         entry_tgt_q, entry_tgt_d;
    logic                taken_q, taken_d;
    logic                hit_q, hit_d;
    logic [WAY_W-1:0]    hit_way_q, hit_way_d;
    logic [NUM_WAYS-1:0] entry_en_q, entry_en_d;
    logic [NUM_WAYS-1:0] update_en_q, update_en_d;
    logic                jump_en_q, jump_en_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [7:0]          evict_q, evict_d;

    logic [WAY_W-1:0]    first_empty;
    logic                any_empty;

    assign res_ready   = (count_q < CNT_W'(FIFO_DEPTH));
    assign fifo_nempty = (count_q != '0);
    assign push        = res_valid & res_ready;
    // Both IDLE and WRITE hand the head record straight to LOOKUP.
    assign pop         = fifo_nempty & ((state_q == IDLE) | (state_q == WRITE));

    assign rec_in     = {res_pc, res_target, res_taken, res_hit, res_hit_way};
    assign head       = fifo_mem[rd_ptr_q];
    assign head_pc    = head[REC_W-1 -: 16];
    assign head_tgt   = head[REC_W-17 -: 16];
    assign head_taken = head[WAY_W+1];
    assign head_hit   = head[WAY_W];
    assign head_hw    = head[WAY_W-1:0];

    // Lowest-index empty way: scanning downward lets the lowest index win.
    always_comb begin
        first_empty = '0;
        any_empty   = 1'b0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (way_empty[i]) begin
                first_empty = WAY_W'(i);
                any_empty   = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        state_d     = state_q;
        entry_pc_d  = entry_pc_q;
        entry_tgt_d = entry_tgt_q;
        taken_d     = taken_q;
        hit_d       = hit_q;
        hit_way_d   = hit_way_q;
        entry_en_d  = '0;
        update_en_d = '0;
        jump_en_d   = 1'b0;
        victim_d    = victim_q;
        evict_d     = evict_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case (state_q)
            IDLE, WRITE: begin
                if (pop) begin
                    entry_pc_d  = head_pc;
                    entry_tgt_d = head_tgt;
                    taken_d     = head_taken;
                    hit_d       = head_hit;
                    hit_way_d   = head_hw;
                    state_d     = LOOKUP;
                end else begin
                    state_d     = IDLE;
                end
            end
            LOOKUP: begin
                if (hit_q) begin
                    // A stale hit way is trusted as-is; no re-check.
                    update_en_d = NUM_WAYS'(1) << hit_way_q;
                    jump_en_d   = taken_q;
                    state_d     = WRITE;
                end else if (taken_q) begin
                    jump_en_d = 1'b1;
                    state_d   = WRITE;
                    if (any_empty) begin
                        entry_en_d = NUM_WAYS'(1) << first_empty;
                    end else begin
                        entry_en_d = NUM_WAYS'(1) << victim_q;
                        victim_d   = victim_q + WAY_W'(1);
                        if (evict_q != 8'hFF) begin
                            evict_d = evict_q + 8'd1;
                        end
                    end
                end else begin
                    // Not-taken miss: nothing worth caching.
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= rec_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            entry_pc_q  <= '0;
            entry_tgt_q <= '0;
            taken_q     <= 1'b0;
            hit_q       <= 1'b0;
            hit_way_q   <= '0;
            entry_en_q  <= '0;
            update_en_q <= '0;
            jump_en_q   <= 1'b0;
            victim_q    <= '0;
            evict_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            entry_pc_q  <= entry_pc_d;
            entry_tgt_q <= entry_tgt_d;
            taken_q     <= taken_d;
            hit_q       <= hit_d;
            hit_way_q   <= hit_way_d;
            entry_en_q  <= entry_en_d;
            update_en_q <= update_en_d;
            jump_en_q   <= jump_en_d;
            victim_q    <= victim_d;
            evict_q     <= evict_d;
        end
    end

    assign entry_pc     = entry_pc_q;
    assign entry_target = entry_tgt_q;
    assign entry_en     = entry_en_q;
    assign update_en    = update_en_q;
    assign jump_en      = jump_en_q;
    assign evict_count  = evict_q;
    assign busy         = fifo_nempty | (state_q != IDLE);

endmodule

// File: tb/tb_btb_update_ctrl.sv
module tb_btb_update_ctrl;

    logic        clk;
    logic        rst;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_pc;
    logic [15:0] res_target;
    logic        res_taken;
    logic        res_hit;
    logic [0:0]  res_hit_way;
    logic [1:0]  way_empty;
    logic [15:0] entry_pc;
    logic [15:0] entry_target;
    logic [1:0]  entry_en;
    logic [1:0]  update_en;
    logic        jump_en;
    logic        busy;
    logic [7:0]  evict_count;

    btb_update_ctrl #(.NUM_WAYS(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_pc(res_pc), .res_target(res_target),
        .res_taken(res_taken), .res_hit(res_hit), .res_hit_way(res_hit_way),
        .way_empty(way_empty),
        .entry_pc(entry_pc), .entry_target(entry_target),
        .entry_en(entry_en), .update_en(update_en), .jump_en(jump_en),
        .busy(busy), .evict_count(evict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input logic [15:0] pc, input logic [15:0] tgt,
                           input logic tk, input logic ht, input logic hw);
        res_pc      = pc;
        res_target  = tgt;
        res_taken   = tk;
        res_hit     = ht;
        res_hit_way = hw;
    endtask

    // Strobe monitor: exclusivity/one-hot violations and a log of strobes.
    int          viol = 0;
    int          cyc  = 0;
    logic        mon_en = 1'b0;
    logic [15:0] s_pc [$];
    logic [1:0]  s_ue [$];
    logic [1:0]  s_ee [$];
    logic        s_j  [$];
    int          s_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if ((|entry_en && |update_en) || $countones(entry_en) > 1 ||
                $countones(update_en) > 1)
                viol++;
        end
        if (mon_en && (|entry_en || |update_en)) begin
            s_pc.push_back(entry_pc);
            s_ue.push_back(update_en);
            s_ee.push_back(entry_en);
            s_j.push_back(jump_en);
            s_cyc.push_back(cyc);
        end
    end

    typedef struct {
        logic [15:0] pc;
        logic [15:0] tgt;
        logic        taken;
        logic        hit;
        logic        hw;
        logic [1:0]  we;
        logic [1:0]  ee;
        logic [1:0]  ue;
        logic        j;
        logic [7:0]  ev;
        logic        busy2;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int idx;
        int c;
        logic acc;
        logic exp_rdy [9];

        vecs[0] = '{16'h0040, 16'h0100, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01, 2'b00, 1'b1, 8'd0, 1'b1};
        vecs[1] = '{16'h1234, 16'h5678, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b10, 1'b0, 8'd0, 1'b1};
        vecs[2] = '{16'h0080, 16'h0200, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 8'd0, 1'b1};
        vecs[3] = '{16'h00C0, 16'h0300, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 8'd1, 1'b1};
        vecs[4] = '{16'h0100, 16'h0400, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b1, 8'd2, 1'b1};
        vecs[5] = '{16'h0140, 16'h0500, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 8'd3, 1'b1};
        vecs[6] = '{16'h0180, 16'h0600, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 8'd3, 1'b0};
        vecs[7] = '{16'h01C0, 16'h0700, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 8'd3, 1'b1};
        vecs[8] = '{16'hFFFE, 16'hFFFF, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 8'd3, 1'b1};

        rst = 1'b0;
        res_valid = 1'b0;
        set_rec(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        way_empty = 2'b00;
        tick();
        tick();
        rst = 1'b1;

        chk("rst_ready", res_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {entry_en, update_en, jump_en}, 0);
        chk("rst_pc", entry_pc, 0);
        chk("rst_evict", evict_count, 0);

        // Single-record vectors, each started from an idle controller.
        for (int v = 0; v < 9; v++) begin
            set_rec(vecs[v].pc, vecs[v].tgt, vecs[v].taken, vecs[v].hit, vecs[v].hw);
            way_empty = vecs[v].we;
            res_valid = 1'b1;
            tick();                       // edge T: push
            res_valid = 1'b0;
            tick();                       // edge T+1: LOOKUP
            chk($sformatf("v%0d_lk_pc", v), entry_pc, vecs[v].pc);
            chk($sformatf("v%0d_lk_strb", v), {entry_en, update_en, jump_en}, 0);
            tick();                       // edge T+2: strobe
            chk($sformatf("v%0d_ee", v), entry_en, vecs[v].ee);
            chk($sformatf("v%0d_ue", v), update_en, vecs[v].ue);
            chk($sformatf("v%0d_j", v), jump_en, vecs[v].j);
            chk($sformatf("v%0d_pc", v), entry_pc, vecs[v].pc);
            chk($sformatf("v%0d_tgt", v), entry_target, vecs[v].tgt);
            chk($sformatf("v%0d_ev", v), evict_count, vecs[v].ev);
            chk($sformatf("v%0d_busy", v), busy, vecs[v].busy2);
            tick();
            chk($sformatf("v%0d_idle", v), {busy, entry_en, update_en, jump_en}, 0);
        end

        // Back-to-back pushes: the FIFO fills after the 7th accepted record.
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        way_empty = 2'b00;
        mon_en = 1'b1;
        idx = 0;
        set_rec(16'h1000, 16'h2000, 1'b0, 1'b1, 1'b0);
        res_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("b2b_ready%0d", k), res_ready, exp_rdy[k]);
            acc = res_valid & res_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx == 8) res_valid = 1'b0;
                else set_rec(16'h1000 + 16'(idx), 16'h2000 + 16'(idx),
                             idx[0], 1'b1, idx[0]);
            end
        end
        c = 0;
        while (busy && c < 40) begin
            tick();
            c++;
        end
        tick();
        mon_en = 1'b0;
        chk("b2b_drained", busy, 0);
        chk("b2b_nstrobe", s_pc.size(), 8);
        for (int i = 0; i < 8 && i < s_pc.size(); i++) begin
            chk($sformatf("b2b_pc%0d", i), s_pc[i], 16'h1000 + 16'(i));
            chk($sformatf("b2b_ue%0d", i), {s_ee[i], s_ue[i]}, (i % 2) ? 4'b0010 : 4'b0001);
            chk($sformatf("b2b_j%0d", i), s_j[i], i % 2);
            if (i > 0) chk($sformatf("b2b_gap%0d", i), s_cyc[i] - s_cyc[i-1], 2);
        end

        // Evict-count saturation: 260 forced replacements starting from 3.
        idx = 0;
        way_empty = 2'b00;
        set_rec(16'h3000, 16'h4000, 1'b1, 1'b0, 1'b0);
        res_valid = 1'b1;
        c = 0;
        while (!(idx == 260 && !busy) && c < 3000) begin
            acc = res_valid & res_ready;
            tick();
            c++;
            if (acc) begin
                idx++;
                if (idx == 260) res_valid = 1'b0;
                else set_rec(16'h3000 + 16'(idx), 16'h4000, 1'b1, 1'b0, 1'b0);
            end
        end
        chk("sat_done", (idx == 260) && !busy, 1);
        chk("sat_evict", evict_count, 8'd255);

        // Reset while a strobe is on the ways and another record is queued.
        set_rec(16'h5000, 16'h6000, 1'b1, 1'b0, 1'b0);
        way_empty = 2'b11;
        res_valid = 1'b1;
        tick();
        set_rec(16'h5002, 16'h6002, 1'b1, 1'b0, 1'b0);
        tick();
        res_valid = 1'b0;
        tick();
        chk("mid_write_ee", entry_en, 2'b01);
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        chk("mr_strobes", {entry_en, update_en, jump_en}, 0);
        chk("mr_ready", res_ready, 1);
        chk("mr_busy", busy, 0);
        chk("mr_evict", evict_count, 0);
        chk("mr_pc", entry_pc, 0);
        tick();
        chk("mr_after_strobes", {entry_en, update_en, jump_en}, 0);
        chk("mr_after_busy", busy, 0);

        chk("onehot_viol", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
